avg_tx: RTL
===========

# avg_tx

Downstream output stage for the 12-sample closest-to-average filter. It decimates the filter's 16-bit result stream and buffers the selected words in a small FIFO. Each word is shifted out MSB-first on a framed one-bit serial link with a simple accept handshake. It sits between the filter's `dout`/`ready` pair and the chip-level serial pad.

## Interface
- `DECIM`, default 24: capture one filter result every DECIM cycles while `ready` is high; legal range 1..255.
- `DEPTH`, default 8: FIFO depth in 16-bit words; power of two, 2..16.
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `ready`  in  1: filter result valid (filter's `ready`).
- `din`  in  16: filter result (filter's `dout`).
- `tx_rdy`  in  1: receiver accepts a new frame; sampled only in IDLE.
- `sdo`  out  1: serial data, MSB first.
- `sframe`  out  1: high for exactly the 16 bit-cycles of a frame.
- `overflow`  out  1: sticky, set when a capture is dropped because the FIFO is full.
- `fifo_cnt`  out  $clog2(DEPTH)+1: words currently held.

## Operation
- **Capture counter `dcnt` (0..DECIM-1):**
  - Held at 0 while `ready`=0.
  - While `ready`=1, a push request is raised in any cycle with `dcnt`==0. `dcnt` then increments and wraps DECIM-1 -> 0.
  - The first push is therefore the first cycle `ready` is high.
  - `ready` falling mid-count returns `dcnt` to 0 at the next edge.
  - DECIM=1 pushes every cycle.
- **FIFO:**
  - Circular buffer with `DEPTH` entries. Read and write pointers wrap modulo DEPTH.
  - `fifo_cnt` ranges 0..DEPTH.
  - A push is accepted if not full, or if a pop occurs in the same cycle; in that case `fifo_cnt` is unchanged.
  - A push is dropped if full with no pop. A dropped push sets `overflow`, which is cleared only by `reset`.
  - A pop on empty never occurs; the FSM gates it.
- **TX FSM, states IDLE and SHIFT:**
  - IDLE: if `fifo_cnt`!=0 and `tx_rdy`=1, pop the head word into the 16-bit shift register, set `bcnt`=15, and go to SHIFT. Otherwise stay.
  - SHIFT: `sframe`=1 and `sdo`=shreg[15]. Each cycle shift left and decrement `bcnt`. After the cycle presenting bit 0, return to IDLE.
  - `tx_rdy` is ignored in SHIFT; a frame, once started, always completes.
  - Frames are separated by at least one cycle with `sframe`=0.
- **Outputs:** `sdo` and `sframe` are registered. In IDLE, `sdo`=0.
- **Reset:**
  - Reset values: `sdo`=0, `sframe`=0, `overflow`=0, `fifo_cnt`=0. FSM goes to IDLE, `dcnt`=0, pointers=0.
  - Reset mid-frame aborts the frame at that edge.
  - Buffered words are discarded.
- The filter's internal reset is independent: any words already in the FIFO are still transmitted after `ready` drops.

## Timing
- **Capture:** push at edge E when `ready`=1 and `dcnt`==0. `fifo_cnt` reflects the push after E.
- **Minimum latency** (empty FIFO, `tx_rdy`=1):
  - Pop at edge E+1.
  - `sframe`=1 and `sdo`=din[15] after E+1.
  - Bit k is presented after edge E+1+(15-k). Bit 0 appears after E+16.
  - `sframe` falls after E+17.
- **Back-to-back frames:** next pop earliest at E+18, so the frame period is 17 cycles.
  - Sustained throughput requires DECIM >= 17; default 24 never overflows with `tx_rdy` held high.
- **Pop and push in the same edge:** both are applied. A word pushed at E can be popped no earlier than E+1.

## Test plan
- **Single word:** reset, `tx_rdy`=1, `ready` rises with `din`=16'hA5C3.
  - Required: `sframe` high for 16 cycles starting 1 cycle after capture.
  - `sdo` sequence is 1010_0101_1100_0011.
  - `fifo_cnt` goes 1 -> 0.
- **Decimation:** DECIM=24, `ready`=1, `din` = cycle index.
  - Required: transmitted words are 0, 24, 48, 72 in order.
  - No `overflow`; `fifo_cnt` never exceeds 1.
- **Backpressure and full:** `tx_rdy`=0, DECIM=1, DEPTH=8, `din`=1..10.
  - Required: `fifo_cnt` saturates at 8 and `overflow` sets on the 9th capture.
  - After `tx_rdy`=1, words 1..8 go out with 1-cycle gaps; 9 and 10 are lost.
- **Simultaneous push/pop at full:** FIFO full, pop coincides with a push.
  - Required: `fifo_cnt` stays 8, `overflow` stays 0, and the pushed word appears last.
- **Mid-frame events:** drop `tx_rdy` during bit 7; the frame completes and no new frame starts.
  - Assert `reset` at bit 4 of the next frame.
  - Required: `sframe`=0 and `sdo`=0 after that edge, with `fifo_cnt`=0 and `overflow`=0.
- **Wrap-around:** DEPTH=4, push/pop 10 words with distinct values.
  - Required: output order is preserved across pointer wrap.

Source files
------------

// File: rtl/avg_tx_if.sv
// avg_tx_if: groups the filter-side capture inputs, the serial link and the
// status outputs of avg_tx into one bundle.
//   ready, din   : filter result valid / 16-bit filter result
//   tx_rdy       : receiver accepts a new frame
//   sdo, sframe  : serial data (MSB first) and frame strobe
//   overflow     : sticky capture-dropped flag
//   fifo_cnt     : words currently buffered (0..DEPTH)
// master = the side that feeds the block; slave = avg_tx itself.
interface avg_tx_if #(
    parameter int unsigned DEPTH = 8
);
    logic                     ready;
    logic [15:0]              din;
    logic                     tx_rdy;
    logic                     sdo;
    logic                     sframe;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   fifo_cnt;

    modport master (
        output ready, din, tx_rdy,
        input  sdo, sframe, overflow, fifo_cnt
    );

    modport slave (
        input  ready, din, tx_rdy,
        output sdo, sframe, overflow, fifo_cnt
    );
endinterface

// File: rtl/avg_tx.sv
// avg_tx: decimates the averaging filter's result stream, buffers selected
// words in a small circular FIFO and shifts each one out MSB-first as a
// 16-bit framed serial word.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : avg_tx_if.slave (ready/din in, tx_rdy in, sdo/sframe out,
//            overflow/fifo_cnt status out)
// Parameters: DECIM (1..255) capture period, DEPTH (power of two, 2..16).
module avg_tx #(
    parameter int unsigned DECIM = 24,
    parameter int unsigned DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    avg_tx_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [7:0]      dcnt_q, dcnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     shreg_q, shreg_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic            sdo_q, sdo_d;
    logic            sframe_q, sframe_d;
    logic [15:0]     mem_q [DEPTH];

    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic [15:0]     head;

    assign head     = mem_q[rd_ptr_q];
    assign full     = (cnt_q == CW'(DEPTH));
    assign push_req = bus.ready && (dcnt_q == 8'd0);
    assign pop      = (state_q == StIdle) && (cnt_q != '0) && bus.tx_rdy;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign push     = push_req && (!full || pop);

    // Capture counter: held at 0 while the filter output is not valid.
    always_comb begin
        dcnt_d = 8'd0;
        if (bus.ready) begin
            dcnt_d = (dcnt_q == 8'(DECIM - 1)) ? 8'd0 : dcnt_q + 8'd1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (push_req && full && !pop);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // TX FSM; sdo/sframe are computed one cycle ahead and registered.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bcnt_d   = bcnt_q;
        sdo_d    = 1'b0;
        sframe_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    shreg_d  = head;
                    bcnt_d   = 4'd15;
                    sdo_d    = head[15];
                    sframe_d = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                if (bcnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    shreg_d  = {shreg_q[14:0], 1'b0};
                    bcnt_d   = bcnt_q - 4'd1;
                    sdo_d    = shreg_q[14];
                    sframe_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            dcnt_q   <= 8'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            shreg_q  <= 16'd0;
            bcnt_q   <= 4'd0;
            sdo_q    <= 1'b0;
            sframe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            shreg_q  <= shreg_d;
            bcnt_q   <= bcnt_d;
            sdo_q    <= sdo_d;
            sframe_q <= sframe_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.din;
    end

    assign bus.sdo      = sdo_q;
    assign bus.sframe   = sframe_q;
    assign bus.overflow = ovf_q;
    assign bus.fifo_cnt = cnt_q;
endmodule
